// File: rtl/tc_pkg.sv
// Shared encodings for the memory-mapped timer: FSM states, register offsets, CTRL layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_PSC_LSB  = 4;

    // Field order mirrors the CTRL bit positions above, LSB last.
    typedef struct packed {
        logic [3:0] psc;
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/tc_prescaler.sv
// Prescale tick generator (TC_PRESCALE_EN builds only): tick fires once every psc+1 run cycles.
// Latency: tick is combinational from the internal count; clr takes effect on the next edge.
// Backpressure: none; counting advances only while run is high.
module tc_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       run,
    input  logic [3:0] psc,
    output logic       tick
);

    logic [3:0] cnt;

    assign tick = run && (cnt == psc);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= 4'd0;
        end else if (run) begin
            cnt <= (cnt == psc) ? 4'd0 : cnt + 4'd1;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Programmable down-counter timer with interrupt; optional prescaler under TC_PRESCALE_EN.
// Latency: reads combinational; EN write loads COUNT two edges later, irq_flag N edges after that.
// Backpressure: none; every bus write is accepted on the edge it is presented.
module timer_counter
    import tc_pkg::*;
#(
    parameter logic [31:0] PRESET_RST = 32'h0,
    parameter int          CNT_W      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_nxt;
    ctrl_t            ctrl, ctrl_wr;
    logic [CNT_W-1:0] preset, count;
    logic             irq_flag;
    logic             wr_ctrl, wr_preset;
    logic             tick;
    logic             do_load, do_dec, do_fire, do_stop;
    logic             unused_addr;

    assign wr_ctrl     = we && (addr[1:0] == REG_CTRL);
    assign wr_preset   = we && (addr[1:0] == REG_PRESET);
    assign unused_addr = ^addr[29:2];

`ifdef TC_PRESCALE_EN
    assign ctrl_wr = ctrl_t'(din[7:0]);

    tc_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (do_load || wr_ctrl),
        .run   (state == CNT),
        .psc   (ctrl.psc),
        .tick  (tick)
    );
`else
    assign ctrl_wr = ctrl_t'({4'd0, din[3:0]});
    assign tick    = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ctrl.en) state_nxt = LOAD;
            LOAD:    state_nxt = CNT;
            CNT: begin
                if (!ctrl.en)     state_nxt = IDLE;
                else if (do_fire) state_nxt = INT;
            end
            INT:     state_nxt = (ctrl.mode == MODE_RELOAD) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Modes 2 and 3 fall back to one-shot behaviour.
    always_comb begin
        do_load = 1'b0;
        do_dec  = 1'b0;
        do_fire = 1'b0;
        do_stop = 1'b0;
        case (state)
            LOAD: do_load = 1'b1;
            CNT: begin
                if (ctrl.en && tick) begin
                    if (count > ONE) do_dec  = 1'b1;
                    else             do_fire = 1'b1;
                end
            end
            INT:     do_stop = (ctrl.mode != MODE_RELOAD);
            default: ;
        endcase
    end

    // A software CTRL write outranks the hardware EN clear at the end of a one-shot.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl <= ctrl_wr;
        end else if (do_stop) begin
            ctrl.en <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            preset <= CNT_W'(PRESET_RST);
        end else if (wr_preset) begin
            preset <= CNT_W'(din);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (do_load) begin
            count <= preset;
        end else if (do_dec) begin
            count <= count - ONE;
        end else if (do_fire) begin
            count <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_flag <= 1'b0;
        end else if (wr_ctrl || wr_preset || do_load) begin
            irq_flag <= 1'b0;
        end else if (do_fire) begin
            irq_flag <= 1'b1;
        end
    end

    assign irq = irq_flag & ctrl.im;

    always_comb begin
        dout = 32'd0;
        case (addr[1:0])
            REG_CTRL:   dout = {24'd0, ctrl};
            REG_PRESET: dout = 32'(preset);
            REG_COUNT:  dout = 32'(count);
            default:    dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: vector table, hand-written corner sequences and randomized
// one-shot/reload runs checked against an arithmetic timing model.
module tb_timer_counter;

    localparam logic [31:0] PR = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        reset, we, irq;
    logic [29:0] addr;
    logic [31:0] din, dout;
    int          tests = 0;
    int          errors = 0;

    timer_counter #(.PRESET_RST(PR), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          w;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp_dout;
        bit          exp_irq;
    } vec_t;

    vec_t vt[$];

`ifdef TC_PRESCALE_EN
    int exp_psc[7] = '{2, 2, 2, 1, 1, 1, 0};
`endif

    function automatic vec_t mk(bit rst, bit w, logic [1:0] a, logic [31:0] d,
                                logic [31:0] e, bit i);
        vec_t v;
        v.rst = rst; v.w = w; v.a = a; v.d = d; v.exp_dout = e; v.exp_irq = i;
        return v;
    endfunction

    function automatic vec_t row_rst();
        return mk(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    endfunction

    function automatic vec_t row_rd(logic [1:0] a, logic [31:0] e, bit i);
        return mk(1'b0, 1'b0, a, 32'd0, e, i);
    endfunction

    function automatic vec_t row_wr(logic [1:0] a, logic [31:0] d, logic [31:0] e, bit i);
        return mk(1'b0, 1'b1, a, d, e, i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Upper address bits are randomized: only A[3:2] may influence the block.
    task automatic set_bus(input bit w, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        r    = $urandom();
        we   = w;
        addr = {r[27:0], a};
        din  = d;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        set_bus(1'b0, a, 32'd0);
        #1;
        v = dout;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        set_bus(1'b1, a, d);
        step();
        we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        we    = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Expected state k edges after the enabling CTRL write, PRESET=n, PSC=0.
    // Timeline: LOAD at k=1, COUNT=n at k=2, terminal at k=2+max(n,1);
    // reload repeats with period max(n,1)+2 starting from the LOAD cycle.
    task automatic model(input int n, input logic [1:0] mode, input int k,
                         output int c, output bit f, output bit e);
        int l, p, q;
        l = (n < 1) ? 1 : n;
        p = l + 2;
        c = 0;
        f = 1'b0;
        e = 1'b1;
        if (mode == 2'd1) begin
            if (k >= 2) begin
                q = (k - 1) % p;
                if (q == 0 || q == l + 1) f = 1'b1;
                else                      c = n - (q - 1);
            end
        end else begin
            e = (k <= l + 2);
            if (k >= l + 2)  f = 1'b1;
            else if (k >= 2) c = n - (k - 2);
        end
    endtask

    task automatic chk_state(input string tag, input int k, input int n,
                             input logic [1:0] mode, input bit im);
        int          c;
        bit          f, e;
        logic [31:0] v;
        model(n, mode, k, c, f, e);
        rd(2'd2, v);
        check($sformatf("%s count n=%0d k=%0d", tag, n, k), v, c);
        check($sformatf("%s irq n=%0d k=%0d", tag, n, k), 32'(irq), 32'(f & im));
        rd(2'd0, v);
        check($sformatf("%s ctrl n=%0d k=%0d", tag, n, k), v, {28'd0, im, mode, e});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached after %0d tests", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int          n, kmax;
        logic [1:0]  mode;
        bit          im;
        logic [31:0] r;

        reset = 1'b1; we = 1'b0; addr = '0; din = '0;
        step();
        step();

        // Reset state of every register.
        vt.push_back(row_rst());
        vt.push_back(row_rd(2'd0, 32'd0, 1'b0));
        vt.push_back(row_rd(2'd1, PR, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd0, 1'b0));
        vt.push_back(row_rd(2'd3, 32'd0, 1'b0));
        // One-shot with IM: 5..0, sticky irq, EN self-clears, PRESET write drops irq.
        vt.push_back(row_wr(2'd1, 32'd5, PR, 1'b0));
        vt.push_back(row_wr(2'd0, 32'h9, 32'd0, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd0, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd0, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd5, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd4, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd3, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd2, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd1, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd0, 1'b1));
        vt.push_back(row_rd(2'd0, 32'h8, 1'b1));
        vt.push_back(row_rd(2'd2, 32'd0, 1'b1));
        vt.push_back(row_wr(2'd1, 32'd5, 32'd5, 1'b1));
        vt.push_back(row_rd(2'd1, 32'd5, 1'b0));
        // Writes to COUNT and offset 3 are ignored; offset 3 reads 0.
        vt.push_back(row_rst());
        vt.push_back(row_wr(2'd1, 32'd4, PR, 1'b0));
        vt.push_back(row_wr(2'd0, 32'h1, 32'd0, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd0, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd0, 1'b0));
        vt.push_back(row_wr(2'd2, 32'hDEAD, 32'd4, 1'b0));
        vt.push_back(row_wr(2'd3, 32'hFFFF_FFFF, 32'd0, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd2, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd1, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd0, 1'b0));
        vt.push_back(row_rd(2'd3, 32'd0, 1'b0));
        // PRESET=0 with IM=0; CTRL write in INT sets IM, clears flag and keeps EN.
        vt.push_back(row_rst());
        vt.push_back(row_wr(2'd1, 32'd0, PR, 1'b0));
        vt.push_back(row_wr(2'd0, 32'h1, 32'd0, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd0, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd0, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd0, 1'b0));
        vt.push_back(row_wr(2'd0, 32'h9, 32'h1, 1'b0));
        vt.push_back(row_rd(2'd0, 32'h9, 1'b0));
        vt.push_back(row_rd(2'd0, 32'h9, 1'b0));
        vt.push_back(row_rd(2'd2, 32'd0, 1'b0));
        vt.push_back(row_rd(2'd0, 32'h9, 1'b1));
        vt.push_back(row_rd(2'd0, 32'h8, 1'b1));

        foreach (vt[i]) begin
            reset = vt[i].rst;
            set_bus(vt[i].w, vt[i].a, vt[i].d);
            #1;
            if (!vt[i].rst) begin
                check($sformatf("vec[%0d] dout", i), dout, vt[i].exp_dout);
                check($sformatf("vec[%0d] irq", i), 32'(irq), 32'(vt[i].exp_irq));
            end
            step();
            we    = 1'b0;
            reset = 1'b0;
        end

        // Auto-reload, then stop mid-count: one last decrement, then frozen.
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 0; k < 13; k++) begin
            chk_state("reload", k, 3, 2'd1, 1'b1);
            step();
        end
        rd(2'd2, v);
        check("reload count before stop", v, 32'd2);
        wr(2'd0, 32'hA);
        for (int k = 0; k < 8; k++) begin
            rd(2'd2, v);
            check($sformatf("frozen count %0d", k), v, 32'd1);
            check($sformatf("frozen irq %0d", k), 32'(irq), 32'd0);
            step();
        end

        // Reset mid-count with COUNT=7.
        do_reset();
        wr(2'd1, 32'd9);
        wr(2'd0, 32'h9);
        repeat (4) step();
        rd(2'd2, v);
        check("pre-reset count", v, 32'd7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd(2'd0, v);
        check("post-reset ctrl", v, 32'd0);
        rd(2'd1, v);
        check("post-reset preset", v, PR);
        rd(2'd2, v);
        check("post-reset count", v, 32'd0);
        check("post-reset irq", 32'(irq), 32'd0);
        step();
        rd(2'd2, v);
        check("idle after reset count", v, 32'd0);

        // Reset drops an asserted irq on the reset edge.
        do_reset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        repeat (3) step();
        check("irq before reset", 32'(irq), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("irq after reset", 32'(irq), 32'd0);

`ifdef TC_PRESCALE_EN
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h21);
        step();
        step();
        for (int i = 0; i < 7; i++) begin
            rd(2'd2, v);
            check($sformatf("prescale count %0d", i), v, exp_psc[i]);
            step();
        end
`endif

        // Randomized runs against the arithmetic timing model.
        for (int t = 0; t < 16; t++) begin
            n    = $urandom_range(0, 12);
            mode = t[0] ? 2'($urandom_range(0, 3)) : 2'd1;
            im   = 1'($urandom_range(0, 1));
            r    = $urandom();
            kmax = 3 * (n + 3) + 4;
            do_reset();
            wr(2'd1, n);
            wr(2'd0, {r[31:8], 4'd0, im, mode, 1'b1});
            for (int k = 0; k <= kmax; k++) begin
                chk_state($sformatf("rnd%0d m%0d", t, mode), k, n, mode, im);
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
